// File: rtl/mp_regfile_sb_pkg.sv
// mp_pkg: shared widths and the half-mask helper used by the register file
// and its scoreboard.
//   MP_HALF_W / MP_WORD_W  : half-register and pair widths
//   mp_pair_mask(lsb, w32) : which halves of one pair an access touches,
//                            as {odd, even}
package mp_pkg;

    localparam int MP_HALF_W = 16;
    localparam int MP_WORD_W = 32;

    // A 32-bit access touches both halves of the pair. A 16-bit access
    // touches only the half selected by bit 0 of the index. Callers expand
    // this to a full NREG-wide mask by matching the pair index (idx >> 1).
    function automatic logic [1:0] mp_pair_mask(input logic lsb, input logic w32);
        if (w32)
            return 2'b11;
        else if (lsb)
            return 2'b10;
        else
            return 2'b01;
    endfunction

endpackage

// File: rtl/mp_regfile_sb_if.sv
// mp_regfile_sb_if: read ports, write-back and scoreboard control of the
// register file, bundled as one interface.
//   master : decode / write-back side (drives indices, write-back, sets)
//   slave  : register file (returns read data, stalls, scoreboard status)
// NREG/NRD must match the parameters of the mp_regfile_sb instance.
interface mp_regfile_sb_if #(
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic [NRD-1:0][AW-1:0] rd_idx;
    logic [NRD-1:0]         rd_en;
    logic [NRD-1:0]         rd_w32;
    logic [NRD-1:0][15:0]   rd_data16;
    logic [NRD-1:0][31:0]   rd_data32;
    logic [NRD-1:0]         rd_stall;

    logic                   wb;
    logic                   wb32;
    logic [AW-1:0]          wb_rd;
    logic [31:0]            wb_data;

    logic                   sb_set;
    logic                   sb_set32;
    logic [AW-1:0]          sb_rd;
    logic                   sb_flush;
    logic                   sb_full;
    logic                   sb_err;
    logic [CW-1:0]          sb_count;

    modport master (
        output rd_idx, rd_en, rd_w32,
        output wb, wb32, wb_rd, wb_data,
        output sb_set, sb_set32, sb_rd, sb_flush,
        input  rd_data16, rd_data32, rd_stall,
        input  sb_full, sb_err, sb_count
    );

    modport slave (
        input  rd_idx, rd_en, rd_w32,
        input  wb, wb32, wb_rd, wb_data,
        input  sb_set, sb_set32, sb_rd, sb_flush,
        output rd_data16, rd_data32, rd_stall,
        output sb_full, sb_err, sb_count
    );

endinterface

// File: rtl/mp_regfile_sb_scoreboard.sv
// mp_scoreboard: per-half busy bits for long-latency producers.
//   sb_set/sb_set32/sb_rd : mark a half (or pair) busy
//   sb_flush              : drop all busy bits
//   clr_mask              : halves being written back this cycle
//   busy                  : current busy vector (half 0 never set)
//   sb_count/full/err     : registered population, near-full, sticky overflow
module mp_scoreboard
    import mp_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int MAXPEND = 8,
    localparam int AW     = $clog2(NREG),
    localparam int CW     = $clog2(NREG + 1)
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            sb_set,
    input  logic            sb_set32,
    input  logic [AW-1:0]   sb_rd,
    input  logic            sb_flush,
    input  logic [NREG-1:0] clr_mask,
    output logic [NREG-1:0] busy,
    output logic [CW-1:0]   sb_count,
    output logic            sb_full,
    output logic            sb_err
);

    logic [1:0]      pm;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] kept;
    logic [NREG-1:0] cand;
    logic [NREG-1:0] busy_d;
    logic [CW-1:0]   cand_cnt;
    logic [CW-1:0]   cnt_d;
    logic            ovf;

    always_comb begin
        pm       = mp_pair_mask(sb_rd[0], sb_set32);
        set_mask = '0;
        for (int h = 1; h < NREG; h++)
            set_mask[h] = sb_set && (int'(sb_rd[AW-1:1]) == (h >> 1)) && pm[h[0]];

        // Clear first, then OR the set in: a half set and written back in
        // the same cycle stays busy for the newer producer.
        kept = busy & ~clr_mask;
        cand = kept | set_mask;

        cand_cnt = '0;
        for (int h = 0; h < NREG; h++)
            cand_cnt = cand_cnt + CW'(cand[h]);

        // Overflow drops the whole set; the clears still go through.
        ovf    = (|set_mask) && (int'(cand_cnt) > MAXPEND);
        busy_d = ovf ? kept : cand;
        if (sb_flush)
            busy_d = '0;

        cnt_d = '0;
        for (int h = 0; h < NREG; h++)
            cnt_d = cnt_d + CW'(busy_d[h]);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            busy     <= '0;
            sb_count <= '0;
            sb_full  <= 1'b0;
            sb_err   <= 1'b0;
        end else begin
            busy     <= busy_d;
            sb_count <= cnt_d;
            sb_full  <= (int'(cnt_d) + 2 > MAXPEND);
            // A flush discards the coincident set, so it cannot overflow.
            if (ovf && !sb_flush)
                sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/mp_regfile_sb.sv
// mp_regfile_sb: NREG 16-bit half-registers (NREG/2 32-bit pairs) with NRD
// asynchronous read ports, one half/pair write-back port, optional
// write-to-read bypass and a per-half busy scoreboard.
//   sys_clk / sys_rst : clock, synchronous active-high reset
//   bus (slave)       : read ports, write-back, scoreboard control/status
// Half 0 is hard zero; pair 0 reads as {half1, 16'h0}.
module mp_regfile_sb
    import mp_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int MAXPEND = 8
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    mp_regfile_sb_if.slave bus
);

    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][MP_HALF_W-1:0] mem_q;
    logic [NREG-1:0][MP_HALF_W-1:0] wdata;
    logic [NREG-1:0][MP_HALF_W-1:0] view;
    logic [NREG-1:0]                wmask;
    logic [NREG-1:0]                busy;
    logic [NREG-1:0]                busy_eff;
    logic [1:0]                     wpm;

    // Write-back decode. The mask excludes half 0 and is suppressed during
    // reset, so it serves both as the storage enable and the busy clear.
    always_comb begin
        wpm   = mp_pair_mask(bus.wb_rd[0], bus.wb32);
        wmask = '0;
        wdata = '0;
        view  = '0;
        for (int h = 1; h < NREG; h++)
            wmask[h] = bus.wb && !sys_rst &&
                       (int'(bus.wb_rd[AW-1:1]) == (h >> 1)) && wpm[h[0]];
        for (int h = 0; h < NREG; h++) begin
            wdata[h] = (bus.wb32 && h[0]) ? bus.wb_data[31:16] : bus.wb_data[15:0];
            view[h]  = ((BYPASS != 0) && wmask[h]) ? wdata[h] : mem_q[h];
        end
        // With bypass, a half written back this cycle is already available.
        busy_eff = (BYPASS != 0) ? (busy & ~wmask) : busy;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mem_q <= '0;
        end else begin
            for (int h = 0; h < NREG; h++)
                if (wmask[h])
                    mem_q[h] <= wdata[h];
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   idx;
        logic [1:0]      pm;
        logic [NREG-1:0] rmask;

        assign idx = bus.rd_idx[i];

        always_comb begin
            pm    = mp_pair_mask(idx[0], bus.rd_w32[i]);
            rmask = '0;
            for (int h = 1; h < NREG; h++)
                rmask[h] = (int'(idx[AW-1:1]) == (h >> 1)) && pm[h[0]];
        end

        assign bus.rd_data16[i] = view[idx];
        assign bus.rd_data32[i] = {view[{idx[AW-1:1], 1'b1}], view[{idx[AW-1:1], 1'b0}]};
        assign bus.rd_stall[i]  = bus.rd_en[i] && (|(busy_eff & rmask));
    end

    mp_scoreboard #(
        .NREG    (NREG),
        .MAXPEND (MAXPEND)
    ) u_sb (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .sb_set   (bus.sb_set),
        .sb_set32 (bus.sb_set32),
        .sb_rd    (bus.sb_rd),
        .sb_flush (bus.sb_flush),
        .clr_mask (wmask),
        .busy     (busy),
        .sb_count (bus.sb_count),
        .sb_full  (bus.sb_full),
        .sb_err   (bus.sb_err)
    );

endmodule

// File: tb/tb_mp_regfile_sb.sv
// Bench for mp_regfile_sb: dut_a (BYPASS=1, MAXPEND=4) runs a vector table,
// dut_b (BYPASS=0, MAXPEND=8) runs hand-written latency sequences.
module tb_mp_regfile_sb;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   nchk    = 0;
    int   nfail   = 0;

    always #5 sys_clk = ~sys_clk;

    mp_regfile_sb_if #(.NREG(32), .NRD(2)) ifa ();
    mp_regfile_sb_if #(.NREG(32), .NRD(2)) ifb ();

    mp_regfile_sb #(.NREG(32), .NRD(2), .BYPASS(1), .MAXPEND(4)) dut_a (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (ifa)
    );

    mp_regfile_sb #(.NREG(32), .NRD(2), .BYPASS(0), .MAXPEND(8)) dut_b (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (ifb)
    );

    typedef struct {
        string       name;
        logic        wb;
        logic        wb32;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        set;
        logic        set32;
        logic [4:0]  sb_rd;
        logic        flush;
        logic        en0;
        logic [4:0]  idx0;     // port 0: 16-bit read
        logic        en1;
        logic        w32_1;
        logic [4:0]  idx1;     // port 1: checked on rd_data32
        logic [15:0] e_d16;
        logic [31:0] e_d32;
        logic [1:0]  e_stall;
        logic [5:0]  e_cnt;
        logic        e_full;
        logic        e_err;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic idle_a();
        ifa.wb = 1'b0; ifa.wb32 = 1'b0; ifa.wb_rd = '0; ifa.wb_data = '0;
        ifa.sb_set = 1'b0; ifa.sb_set32 = 1'b0; ifa.sb_rd = '0; ifa.sb_flush = 1'b0;
        ifa.rd_idx = '0; ifa.rd_en = '0; ifa.rd_w32 = '0;
    endtask

    task automatic idle_b();
        ifb.wb = 1'b0; ifb.wb32 = 1'b0; ifb.wb_rd = '0; ifb.wb_data = '0;
        ifb.sb_set = 1'b0; ifb.sb_set32 = 1'b0; ifb.sb_rd = '0; ifb.sb_flush = 1'b0;
        ifb.rd_idx = '0; ifb.rd_en = '0; ifb.rd_w32 = '0;
    endtask

    task automatic apply(input vec_t v);
        ifa.wb = v.wb; ifa.wb32 = v.wb32; ifa.wb_rd = v.wb_rd; ifa.wb_data = v.wb_data;
        ifa.sb_set = v.set; ifa.sb_set32 = v.set32; ifa.sb_rd = v.sb_rd; ifa.sb_flush = v.flush;
        ifa.rd_en = {v.en1, v.en0};
        ifa.rd_w32 = {v.w32_1, 1'b0};
        ifa.rd_idx[0] = v.idx0;
        ifa.rd_idx[1] = v.idx1;
    endtask

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        //          name          wb   wb32 wb_rd  wb_data       set  s32  sb_rd  flsh en0  idx0   en1  w32  idx1   d16      d32           stall  cnt   full err
        vt[0]  = '{"reset_rd",   1'b0,1'b0,5'd0, 32'h0,        1'b0,1'b0,5'd0, 1'b0,1'b1,5'd6, 1'b1,1'b1,5'd6, 16'h0,   32'h0,        2'b00, 6'd0, 1'b0,1'b0};
        vt[1]  = '{"byp32",      1'b1,1'b1,5'd6, 32'hDEADBEEF, 1'b0,1'b0,5'd0, 1'b0,1'b1,5'd7, 1'b1,1'b1,5'd6, 16'hDEAD,32'hDEADBEEF, 2'b00, 6'd0, 1'b0,1'b0};
        vt[2]  = '{"rd_after",   1'b0,1'b0,5'd0, 32'h0,        1'b0,1'b0,5'd0, 1'b0,1'b1,5'd6, 1'b1,1'b1,5'd7, 16'hBEEF,32'hDEADBEEF, 2'b00, 6'd0, 1'b0,1'b0};
        vt[3]  = '{"wb_h1",      1'b1,1'b0,5'd1, 32'h00001234, 1'b0,1'b0,5'd0, 1'b0,1'b1,5'd0, 1'b1,1'b1,5'd0, 16'h0,   32'h12340000, 2'b00, 6'd0, 1'b0,1'b0};
        vt[4]  = '{"wb_h0",      1'b1,1'b0,5'd0, 32'h0000FFFF, 1'b0,1'b0,5'd0, 1'b0,1'b1,5'd0, 1'b1,1'b1,5'd1, 16'h0,   32'h12340000, 2'b00, 6'd0, 1'b0,1'b0};
        vt[5]  = '{"set32_4",    1'b0,1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd4, 1'b0,1'b1,5'd5, 1'b1,1'b1,5'd4, 16'h0,   32'h0,        2'b00, 6'd0, 1'b0,1'b0};
        vt[6]  = '{"stall5",     1'b0,1'b0,5'd0, 32'h0,        1'b0,1'b0,5'd0, 1'b0,1'b1,5'd5, 1'b1,1'b1,5'd4, 16'h0,   32'h0,        2'b11, 6'd2, 1'b0,1'b0};
        vt[7]  = '{"wb5_unstl",  1'b1,1'b0,5'd5, 32'hAAAA5555, 1'b0,1'b0,5'd0, 1'b0,1'b1,5'd5, 1'b1,1'b0,5'd4, 16'h5555,32'h55550000, 2'b10, 6'd2, 1'b0,1'b0};
        vt[8]  = '{"cnt1",       1'b0,1'b0,5'd0, 32'h0,        1'b0,1'b0,5'd0, 1'b0,1'b1,5'd4, 1'b1,1'b1,5'd5, 16'h0,   32'h55550000, 2'b11, 6'd1, 1'b0,1'b0};
        vt[9]  = '{"clr4_set2",  1'b1,1'b0,5'd4, 32'h00004444, 1'b1,1'b0,5'd2, 1'b0,1'b1,5'd4, 1'b1,1'b1,5'd2, 16'h4444,32'h0,        2'b00, 6'd1, 1'b0,1'b0};
        vt[10] = '{"set3",       1'b0,1'b0,5'd0, 32'h0,        1'b1,1'b0,5'd3, 1'b0,1'b1,5'd2, 1'b1,1'b1,5'd6, 16'h0,   32'hDEADBEEF, 2'b01, 6'd1, 1'b0,1'b0};
        vt[11] = '{"set8",       1'b0,1'b0,5'd0, 32'h0,        1'b1,1'b0,5'd8, 1'b0,1'b1,5'd3, 1'b1,1'b1,5'd8, 16'h0,   32'h0,        2'b01, 6'd2, 1'b0,1'b0};
        vt[12] = '{"ovf",        1'b0,1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd10,1'b0,1'b1,5'd8, 1'b1,1'b1,5'd10,16'h0,   32'h0,        2'b01, 6'd3, 1'b1,1'b0};
        vt[13] = '{"err",        1'b0,1'b0,5'd0, 32'h0,        1'b0,1'b0,5'd0, 1'b0,1'b1,5'd10,1'b1,1'b1,5'd11,16'h0,   32'h0,        2'b00, 6'd3, 1'b1,1'b1};
        vt[14] = '{"flush",      1'b0,1'b0,5'd0, 32'h0,        1'b1,1'b0,5'd12,1'b1,1'b1,5'd2, 1'b1,1'b1,5'd12,16'h0,   32'h0,        2'b01, 6'd3, 1'b1,1'b1};
        vt[15] = '{"post_flush", 1'b0,1'b0,5'd0, 32'h0,        1'b0,1'b0,5'd0, 1'b0,1'b1,5'd2, 1'b1,1'b1,5'd12,16'h0,   32'h0,        2'b00, 6'd0, 1'b0,1'b1};
        vt[16] = '{"same_cyc",   1'b1,1'b0,5'd9, 32'h00009999, 1'b1,1'b0,5'd9, 1'b0,1'b1,5'd9, 1'b1,1'b1,5'd6, 16'h9999,32'hDEADBEEF, 2'b00, 6'd0, 1'b0,1'b1};
        vt[17] = '{"same_chk",   1'b0,1'b0,5'd0, 32'h0,        1'b0,1'b0,5'd0, 1'b0,1'b1,5'd9, 1'b1,1'b1,5'd8, 16'h9999,32'h99990000, 2'b11, 6'd1, 1'b0,1'b1};
        vt[18] = '{"set_again",  1'b0,1'b0,5'd0, 32'h0,        1'b1,1'b0,5'd9, 1'b0,1'b1,5'd9, 1'b0,1'b1,5'd0, 16'h9999,32'h12340000, 2'b01, 6'd1, 1'b0,1'b1};
        vt[19] = '{"no_dup",     1'b0,1'b0,5'd0, 32'h0,        1'b0,1'b0,5'd0, 1'b0,1'b0,5'd9, 1'b0,1'b1,5'd0, 16'h9999,32'h12340000, 2'b00, 6'd1, 1'b0,1'b1};

        idle_a();
        idle_b();
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            apply(vt[i]);
            @(negedge sys_clk);
            chk({vt[i].name, ".d16"},   32'(ifa.rd_data16[0]), 32'(vt[i].e_d16));
            chk({vt[i].name, ".d32"},   ifa.rd_data32[1],      vt[i].e_d32);
            chk({vt[i].name, ".stall"}, 32'(ifa.rd_stall),     32'(vt[i].e_stall));
            chk({vt[i].name, ".cnt"},   32'(ifa.sb_count),     32'(vt[i].e_cnt));
            chk({vt[i].name, ".full"},  32'(ifa.sb_full),      32'(vt[i].e_full));
            chk({vt[i].name, ".err"},   32'(ifa.sb_err),       32'(vt[i].e_err));
            next_cycle();
        end

        // Reset mid-operation: the write-back and set in the reset cycle are lost.
        idle_a();
        sys_rst = 1'b1;
        ifa.wb = 1'b1; ifa.wb32 = 1'b1; ifa.wb_rd = 5'd6; ifa.wb_data = 32'h11111111;
        ifa.sb_set = 1'b1; ifa.sb_rd = 5'd3;
        next_cycle();
        sys_rst = 1'b0;
        idle_a();
        ifa.rd_en = 2'b11; ifa.rd_w32 = 2'b10;
        ifa.rd_idx[0] = 5'd3; ifa.rd_idx[1] = 5'd6;
        @(negedge sys_clk);
        chk("rst_mid.cnt",   32'(ifa.sb_count), 32'd0);
        chk("rst_mid.err",   32'(ifa.sb_err),   32'd0);
        chk("rst_mid.full",  32'(ifa.sb_full),  32'd0);
        chk("rst_mid.d32",   ifa.rd_data32[1],  32'h0);
        chk("rst_mid.stall", 32'(ifa.rd_stall), 32'd0);
        ifa.rd_idx[0] = 5'd9;
        #1;
        chk("rst_mid.d16_9", 32'(ifa.rd_data16[0]), 32'h0);
        next_cycle();

        // No-bypass instance: writes and clears show up one cycle later.
        ifb.wb = 1'b1; ifb.wb32 = 1'b1; ifb.wb_rd = 5'd6; ifb.wb_data = 32'hDEADBEEF;
        ifb.rd_en = 2'b11; ifb.rd_w32 = 2'b10;
        ifb.rd_idx[0] = 5'd7; ifb.rd_idx[1] = 5'd6;
        @(negedge sys_clk);
        chk("b_nobyp.d32", ifb.rd_data32[1],      32'h0);
        chk("b_nobyp.d16", 32'(ifb.rd_data16[0]), 32'h0);
        next_cycle();
        ifb.wb = 1'b0;
        @(negedge sys_clk);
        chk("b_late.d32",   ifb.rd_data32[1],      32'hDEADBEEF);
        chk("b_late.d16_7", 32'(ifb.rd_data16[0]), 32'h0000DEAD);
        ifb.rd_idx[0] = 5'd6;
        #1;
        chk("b_late.d16_6", 32'(ifb.rd_data16[0]), 32'h0000BEEF);
        next_cycle();

        ifb.sb_set = 1'b1; ifb.sb_rd = 5'd5;
        ifb.rd_en = 2'b01; ifb.rd_w32 = 2'b00; ifb.rd_idx[0] = 5'd5;
        @(negedge sys_clk);
        chk("b_set.stall0", 32'(ifb.rd_stall), 32'd0);
        next_cycle();
        ifb.sb_set = 1'b0;
        @(negedge sys_clk);
        chk("b_set.stall1", 32'(ifb.rd_stall), 32'd1);
        chk("b_set.cnt",    32'(ifb.sb_count), 32'd1);
        next_cycle();
        ifb.wb = 1'b1; ifb.wb32 = 1'b0; ifb.wb_rd = 5'd5; ifb.wb_data = 32'h00000005;
        @(negedge sys_clk);
        chk("b_clr.stall_held", 32'(ifb.rd_stall),     32'd1);
        chk("b_clr.d16_old",    32'(ifb.rd_data16[0]), 32'h0);
        next_cycle();
        ifb.wb = 1'b0;
        @(negedge sys_clk);
        chk("b_clr.stall_gone", 32'(ifb.rd_stall),     32'd0);
        chk("b_clr.d16_new",    32'(ifb.rd_data16[0]), 32'h5);
        chk("b_clr.cnt",        32'(ifb.sb_count),     32'd0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/mp_regfile_sb.md
# mp_regfile_sb

Parametrised successor to the core register file: `NREG` 16-bit half-registers organised as `NREG/2` 32-bit pairs, `NRD` asynchronous read ports, one half/full write-back port with optional same-cycle write-to-read bypass, and a per-half busy scoreboard. The scoreboard tracks long-latency producers (LSU, sysbus) and raises per-port stall, replacing ad-hoc hazard compares in the core. It sits between decode and the execution units, fed by the write-back mux.

## Interface
- `NREG`, 32, number of 16-bit half-registers; even, ≥4; `AW = $clog2(NREG)`
- `NRD`, 2, number of read ports, 1..4
- `BYPASS`, 1, 1 = write-back data and busy-clear visible to reads in the same cycle
- `MAXPEND`, 8, max simultaneously busy halves, 2..NREG-1
- `sys_clk` in 1 — clock, all state on rising edge
- `sys_rst` in 1 — reset, synchronous, active-high
- `rd_idx` in NRD*AW — per-port half index; 32-bit reads ignore bit 0
- `rd_en` in NRD — port in use (qualifies stall only)
- `rd_w32` in NRD — port reads a 32-bit pair
- `rd_data16` out NRD*16 — half value
- `rd_data32` out NRD*32 — pair value `{odd, even}`
- `rd_stall` out NRD — `rd_en` and a referenced half busy
- `wb` in 1, `wb32` in 1, `wb_rd` in AW, `wb_data` in 32 — write-back; 16-bit writes use `wb_data[15:0]`
- `sb_set` in 1, `sb_set32` in 1, `sb_rd` in AW — mark destination busy
- `sb_flush` in 1 — clear all busy bits
- `sb_full` out 1 — fewer than 2 free pending slots
- `sb_err` out 1 — sticky: set refused for overflow
- `sb_count` out $clog2(NREG+1) — busy halves

## Operation
- Half 0 is hard zero: writes to it are discarded, it is never busy; `rd_data16` of index 0 = 0; `rd_data32` of pair 0 = `{half1, 16'h0}`.
- Write: `wb32` writes both halves of pair `wb_rd[AW-1:1]` (`[31:16]` → odd); otherwise writes half `wb_rd` only.
- Read: combinational from storage; if `BYPASS`, the written half/halves are replaced by `wb_data` in the same cycle (per half).
- Scoreboard set: `sb_set32` marks both halves of the pair, otherwise half `sb_rd`; half 0 is excluded. Setting an already-busy half does not change the count.
- Scoreboard clear: every `wb` clears the busy bits of the halves it writes, whether or not they were set.
- Same half set and cleared in one cycle: set wins (newer producer).
- Overflow: a set that would make `sb_count > MAXPEND` is dropped entirely (neither half marked) and sets `sb_err`; clears in that cycle still apply.
- `sb_flush`: all busy bits and count → 0 next cycle; a simultaneous set is ignored; register contents are kept.
- `rd_stall[i]` = `rd_en[i]` and (referenced half, or either half if `rd_w32`) busy. If `BYPASS`, a half cleared by a `wb` in the same cycle does not count as busy.
- `sb_full` = `MAXPEND - sb_count < 2`.

## Timing
- Reset: all halves 0, busy 0, `sb_count` 0, `sb_err` 0, `sb_full` 0. Reset mid-operation discards pending state; `wb`/`sb_set` in the reset cycle are ignored.
- Write-to-read latency: 0 cycles if `BYPASS`, else 1.
- Set-to-stall latency: 1 cycle. Clear-to-unstall latency: 0 cycles if `BYPASS`, else 1.
- `sb_count`, `sb_full`, `sb_err` are registered; they update on the edge after the causing event.

## Structure
- The shared package `mp_pkg` holds `MP_HALF_W=16`, `MP_WORD_W=32`, and a helper function for the half-mask from `(idx, w32)`.
- Sub-module `mp_scoreboard` contains the busy vector, count, full/err, and the clear/set priority. The top level holds storage, the read mux, and bypass.

## Test plan
- Reset, then read all ports → data 0, `rd_stall` 0, `sb_count` 0.
- `wb32` `wb_rd`=6 `wb_data`=32'hDEAD_BEEF with a same-cycle 32-bit read of idx 6 → `BYPASS`=1: `DEAD_BEEF` same cycle; `BYPASS`=0: next cycle. 16-bit reads of idx 7 → `DEAD`, idx 6 → `BEEF`.
- `wb` `wb_rd`=1 data 0x1234, then 32-bit read of idx 0 → `32'h1234_0000`; 16-bit read of idx 0 → 0.
- `sb_set32` `sb_rd`=4, next cycle `rd_en` 16-bit read of idx 5 → stall 1, count 2; 16-bit `wb` to 5 → idx 5 unstalls in the same cycle (`BYPASS`=1), idx 4 still busy, count 1.
- `MAXPEND`=4: sets on halves 2, 3, 8 → count 3, `sb_full` 1; 32-bit set on pair 10 → refused, `sb_err` 1, count 3; `sb_flush` → count 0, `sb_err` stays 1.
- Same cycle: set half 9 and `wb` half 9 → busy remains, count +1.
